// File: rtl/map_irq_pkg.sv
// Shared constants for the mapper IRQ timer bank: register offsets, save-state
// layout, control bit positions and the per-channel flag record.
package map_irq_pkg;

    localparam logic [2:0] OFF_RLO  = 3'd0;
    localparam logic [2:0] OFF_RHI  = 3'd1;
    localparam logic [2:0] OFF_CTRL = 3'd2;
    localparam logic [2:0] OFF_STRB = 3'd3;
    localparam logic [2:0] OFF_ACK  = 3'd4;

    localparam logic [2:0] SS_CLO = 3'd0;
    localparam logic [2:0] SS_CHI = 3'd1;
    localparam logic [2:0] SS_RLO = 3'd2;
    localparam logic [2:0] SS_RHI = 3'd3;
    localparam logic [2:0] SS_FLG = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AR   = 1;
    localparam int CTRL_MASK = 2;

    localparam logic [7:0] BLOCK_ID   = 8'h41;
    localparam logic [7:0] SS_ID_ADDR = 8'd127;

    // Field order matches the save-state flag byte {req, pend, mask, ar, en}.
    typedef struct packed {
        logic req;
        logic pend;
        logic mask;
        logic ar;
        logic en;
    } chan_flags_t;

    localparam chan_flags_t RST_FLAGS = 5'b00100;

endpackage

// File: rtl/map_irq_chan.sv
// One timer channel: CW-bit down-counter with reload, one-shot/auto-reload,
// mask, level pending flag and save-state load port. Updates on negedge m2.
module map_irq_chan
    import map_irq_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          m2,
    input  logic          map_rst_n,
    input  logic          run,
    input  logic          wr_rlo,
    input  logic          wr_rhi,
    input  logic          wr_ctrl,
    input  logic          wr_strb,
    input  logic          wr_ack,
    input  logic [7:0]    reg_dat,
    input  logic          ss_wr,
    input  logic [2:0]    ss_off,
    input  logic [7:0]    ss_wdat,
    output logic [CW-1:0] ctr,
    output logic [CW-1:0] reload,
    output chan_flags_t   flags
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] ctr_q, ctr_d;
    logic [CW-1:0] reload_q, reload_d;
    chan_flags_t   flags_q, flags_d;
    logic [15:0]   ctr16, rl16;
    logic          evt;

    always_comb begin
        ctr_d   = ctr_q;
        reload_d = reload_q;
        flags_d = flags_q;
        ctr16   = 16'(ctr_q);
        rl16    = 16'(reload_q);
        evt     = run && !flags_q.req && flags_q.en && (ctr_q == ONE);

        if (run) begin
            if (flags_q.req) begin
                ctr_d        = reload_q;
                flags_d.pend = 1'b0;
                flags_d.req  = 1'b0;
            end else if (flags_q.en && ctr_q != '0) begin
                // Auto-reload takes the reload value from before this edge's writes.
                ctr_d = evt ? (flags_q.ar ? reload_q : '0) : ctr_q - ONE;
            end

            if (wr_rlo) begin
                rl16[7:0] = reg_dat;
                reload_d  = rl16[CW-1:0];
            end
            if (wr_rhi) begin
                rl16[15:8] = reg_dat;
                reload_d   = rl16[CW-1:0];
            end
            if (wr_ctrl) begin
                flags_d.en   = reg_dat[CTRL_EN];
                flags_d.ar   = reg_dat[CTRL_AR];
                flags_d.mask = reg_dat[CTRL_MASK];
                flags_d.pend = 1'b0;
            end
            if (wr_ack) begin
                flags_d.pend = 1'b0;
            end
            if (wr_strb) begin
                flags_d.req = 1'b1;
            end
            // A new event overrides any same-edge clear so no interrupt is lost.
            if (evt) begin
                flags_d.pend = 1'b1;
            end
        end else if (ss_wr) begin
            case (ss_off)
                SS_CLO: begin ctr16[7:0]  = ss_wdat; ctr_d    = ctr16[CW-1:0]; end
                SS_CHI: begin ctr16[15:8] = ss_wdat; ctr_d    = ctr16[CW-1:0]; end
                SS_RLO: begin rl16[7:0]   = ss_wdat; reload_d = rl16[CW-1:0];  end
                SS_RHI: begin rl16[15:8]  = ss_wdat; reload_d = rl16[CW-1:0];  end
                SS_FLG: flags_d = chan_flags_t'(ss_wdat[4:0]);
                default: ;
            endcase
        end
    end

    // Reset is ignored while a save-state session holds the channel.
    always_ff @(negedge m2) begin
        if (!map_rst_n && run) begin
            ctr_q    <= '0;
            reload_q <= '0;
            flags_q  <= RST_FLAGS;
        end else begin
            ctr_q    <= ctr_d;
            reload_q <= reload_d;
            flags_q  <= flags_d;
        end
    end

    assign ctr    = ctr_q;
    assign reload = reload_q;
    assign flags  = flags_q;

endmodule

// File: rtl/map_irq_timer.sv
// Bank of CH mapper IRQ timers: register decode, save-state readback mux and
// interrupt OR-reduction around map_irq_chan instances.
module map_irq_timer
    import map_irq_pkg::*;
#(
    parameter int CH = 2,
    parameter int CW = 16
) (
    input  logic          m2,
    input  logic          map_rst_n,
    input  logic          reg_we,
    input  logic [5:0]    reg_addr,
    input  logic [7:0]    reg_dat,
    input  logic          ss_act,
    input  logic          ss_we,
    input  logic [7:0]    ss_addr,
    input  logic [7:0]    ss_wdat,
    output logic [7:0]    ss_rdat,
    output logic [CH-1:0] irq_vec,
    output logic          irq
);

    logic [15:0] ctr16 [CH];
    logic [15:0] rl16  [CH];
    chan_flags_t flg   [CH];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam logic [2:0] CI = 3'(c);
        logic          hit;
        logic          ss_hit;
        logic [CW-1:0] ctr_w, rl_w;

        assign hit    = reg_we && (reg_addr[5:3] == CI);
        assign ss_hit = ss_act && ss_we && (ss_addr[7:6] == 2'b00) && (ss_addr[5:3] == CI);

        map_irq_chan #(.CW(CW)) u_chan (
            .m2       (m2),
            .map_rst_n(map_rst_n),
            .run      (!ss_act),
            .wr_rlo   (hit && reg_addr[2:0] == OFF_RLO),
            .wr_rhi   (hit && reg_addr[2:0] == OFF_RHI),
            .wr_ctrl  (hit && reg_addr[2:0] == OFF_CTRL),
            .wr_strb  (hit && reg_addr[2:0] == OFF_STRB),
            .wr_ack   (hit && reg_addr[2:0] == OFF_ACK),
            .reg_dat  (reg_dat),
            .ss_wr    (ss_hit),
            .ss_off   (ss_addr[2:0]),
            .ss_wdat  (ss_wdat),
            .ctr      (ctr_w),
            .reload   (rl_w),
            .flags    (flg[c])
        );

        assign ctr16[c]   = 16'(ctr_w);
        assign rl16[c]    = 16'(rl_w);
        assign irq_vec[c] = flg[c].pend & flg[c].mask;
    end

    assign irq = |irq_vec;

    always_comb begin
        ss_rdat = 8'hFF;
        if (ss_addr == SS_ID_ADDR) begin
            ss_rdat = BLOCK_ID;
        end else if (ss_addr[7:6] == 2'b00) begin
            for (int c = 0; c < CH; c++) begin
                if (ss_addr[5:3] == 3'(c)) begin
                    case (ss_addr[2:0])
                        SS_CLO:  ss_rdat = ctr16[c][7:0];
                        SS_CHI:  ss_rdat = ctr16[c][15:8];
                        SS_RLO:  ss_rdat = rl16[c][7:0];
                        SS_RHI:  ss_rdat = rl16[c][15:8];
                        SS_FLG:  ss_rdat = {3'b000, flg[c]};
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
